// File: rtl/mem_stage_lsu_pkg.sv
// Shared encodings for the MEM-stage load unit: load opcodes, FSM states and the alignment rule.
package mem_stage_lsu_pkg;

  localparam logic [2:0] LD_W  = 3'd0;
  localparam logic [2:0] LD_B  = 3'd1;
  localparam logic [2:0] LD_H  = 3'd2;
  localparam logic [2:0] LD_BU = 3'd3;
  localparam logic [2:0] LD_HU = 3'd4;
  localparam logic [2:0] LD_D  = 3'd5;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_WAIT  = 2'd1,
    ST_FULL  = 2'd2,
    ST_DRAIN = 2'd3
  } lsu_state_e;

  // LD_D is only a doubleword access on a 64-bit datapath; otherwise it behaves as LD_W.
  function automatic logic is_misaligned(input logic [2:0] op, input logic [2:0] off,
                                         input logic is64);
    logic mis;
    case (op)
      LD_B, LD_BU: mis = 1'b0;
      LD_H, LD_HU: mis = off[0];
      LD_D:        mis = is64 ? (off != 3'd0) : (off[1:0] != 2'd0);
      default:     mis = (off[1:0] != 2'd0);
    endcase
    return mis;
  endfunction

endpackage

// File: rtl/mem_stage_lsu_load_align.sv
// Sub-word load extraction: picks byte/half/word out of the aligned response and extends it.
module mem_stage_lsu_load_align
  import mem_stage_lsu_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic [2:0]                   op_i,
  input  logic [$clog2(DATA_W/8)-1:0]  off_i,
  input  logic [DATA_W-1:0]            rdata_i,
  output logic [DATA_W-1:0]            data_o
);

  localparam int OFF_W = $clog2(DATA_W/8);

  logic [7:0]        byte_v;
  logic [15:0]       half_v;
  logic [DATA_W-1:0] word_ext;

  assign byte_v = 8'(rdata_i >> {off_i, 3'b000});
  assign half_v = 16'(rdata_i >> {off_i[OFF_W-1:1], 4'b0000});

  generate
    if (DATA_W == 64) begin : g_w64
      logic [31:0] word_v;
      assign word_v   = 32'(rdata_i >> {off_i[OFF_W-1:2], 5'b00000});
      assign word_ext = {{32{word_v[31]}}, word_v};
    end else begin : g_w32
      assign word_ext = rdata_i;
    end
  endgenerate

  always_comb begin
    data_o = word_ext;
    case (op_i)
      LD_B:    data_o = {{(DATA_W-8){byte_v[7]}}, byte_v};
      LD_BU:   data_o = {{(DATA_W-8){1'b0}}, byte_v};
      LD_H:    data_o = {{(DATA_W-16){half_v[15]}}, half_v};
      LD_HU:   data_o = {{(DATA_W-16){1'b0}}, half_v};
      LD_D:    data_o = (DATA_W == 64) ? rdata_i : word_ext;
      default: data_o = word_ext;
    endcase
  end

endmodule

// File: rtl/mem_stage_lsu.sv
// MEM pipeline stage holding one instruction, with variable-latency load responses and flush.
// Optional misaligned-load trap output enabled by MEM_ALIGN_CHECK_EN.
//
// state | meaning
// EMPTY | no instruction held
// WAIT  | load held, response outstanding
// FULL  | result held
// DRAIN | flushed load, response still owed
module mem_stage_lsu
  import mem_stage_lsu_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5,
  parameter int PC_W   = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              ex_to_mem_valid,
  output logic              o_mem_ready,
  input  logic              ex_to_mem_mem_re,
  input  logic [2:0]        ex_to_mem_mem_op,
  input  logic [DATA_W-1:0] ex_to_mem_alu_res,
  input  logic [REG_AW-1:0] ex_to_mem_rf_waddr,
  input  logic              ex_to_mem_rf_we,
  input  logic [PC_W-1:0]   ex_to_mem_pc,
  input  logic [PC_W-1:0]   ex_to_mem_inst,
  input  logic              dmem_rvalid,
  input  logic [DATA_W-1:0] dmem_rdata,
  output logic              mem_to_wb_valid,
  input  logic              i_wb_ready,
  output logic              mem_to_wb_mem_re,
  output logic [DATA_W-1:0] mem_to_wb_rf_wdata,
  output logic [REG_AW-1:0] mem_to_wb_rf_waddr,
  output logic              mem_to_wb_rf_we,
  output logic [PC_W-1:0]   mem_to_wb_pc,
  output logic [PC_W-1:0]   mem_to_wb_inst,
  output logic              mem_load_pending
`ifdef MEM_ALIGN_CHECK_EN
  ,
  output logic              mem_to_wb_ale
`endif
);

  localparam int OFF_W = $clog2(DATA_W/8);

  lsu_state_e        state_q, state_d;
  logic              mem_re_q, mem_re_d;
  logic              we_q, we_d;
  logic [2:0]        op_q, op_d;
  logic [OFF_W-1:0]  off_q, off_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [REG_AW-1:0] waddr_q, waddr_d;
  logic [PC_W-1:0]   pc_q, pc_d;
  logic [PC_W-1:0]   inst_q, inst_d;
  logic [DATA_W-1:0] load_data;
  logic              ready, accept, new_ale, held;

  mem_stage_lsu_load_align #(.DATA_W(DATA_W)) u_align (
    .op_i    (op_q),
    .off_i   (off_q),
    .rdata_i (dmem_rdata),
    .data_o  (load_data)
  );

`ifdef MEM_ALIGN_CHECK_EN
  assign new_ale = ex_to_mem_mem_re &&
                   is_misaligned(ex_to_mem_mem_op, 3'(ex_to_mem_alu_res[OFF_W-1:0]), DATA_W == 64);
`else
  assign new_ale = 1'b0;
`endif

  always_comb begin
    ready = 1'b0;
    case (state_q)
      ST_EMPTY: ready = 1'b1;
      ST_FULL:  ready = i_wb_ready;
      ST_WAIT:  ready = dmem_rvalid && i_wb_ready;
      default:  ready = 1'b0;
    endcase
  end

  assign accept = ex_to_mem_valid && ready && !flush;

  always_comb begin
    state_d  = state_q;
    mem_re_d = mem_re_q;
    we_d     = we_q;
    op_d     = op_q;
    off_d    = off_q;
    wdata_d  = wdata_q;
    waddr_d  = waddr_q;
    pc_d     = pc_q;
    inst_d   = inst_q;
    case (state_q)
      ST_EMPTY: state_d = ST_EMPTY;
      ST_FULL: begin
        if (flush || i_wb_ready) state_d = ST_EMPTY;
      end
      ST_WAIT: begin
        if (flush) begin
          state_d = dmem_rvalid ? ST_EMPTY : ST_DRAIN;
        end else if (dmem_rvalid) begin
          if (i_wb_ready) begin
            state_d = ST_EMPTY;
          end else begin
            state_d = ST_FULL;
            wdata_d = load_data;
          end
        end
      end
      ST_DRAIN: begin
        if (dmem_rvalid) state_d = ST_EMPTY;
      end
      default: state_d = ST_EMPTY;
    endcase
    // Accept is only possible once the held entry has left, so it overrides the above.
    if (accept) begin
      state_d  = (ex_to_mem_mem_re && !new_ale) ? ST_WAIT : ST_FULL;
      mem_re_d = ex_to_mem_mem_re && !new_ale;
      we_d     = ex_to_mem_rf_we && !new_ale;
      op_d     = ex_to_mem_mem_op;
      off_d    = ex_to_mem_alu_res[OFF_W-1:0];
      wdata_d  = ex_to_mem_alu_res;
      waddr_d  = ex_to_mem_rf_waddr;
      pc_d     = ex_to_mem_pc;
      inst_d   = ex_to_mem_inst;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= ST_EMPTY;
      mem_re_q <= 1'b0;
      we_q     <= 1'b0;
      op_q     <= '0;
      off_q    <= '0;
      wdata_q  <= '0;
      waddr_q  <= '0;
      pc_q     <= '0;
      inst_q   <= '0;
    end else begin
      state_q  <= state_d;
      mem_re_q <= mem_re_d;
      we_q     <= we_d;
      op_q     <= op_d;
      off_q    <= off_d;
      wdata_q  <= wdata_d;
      waddr_q  <= waddr_d;
      pc_q     <= pc_d;
      inst_q   <= inst_d;
    end
  end

`ifdef MEM_ALIGN_CHECK_EN
  logic ale_q;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)        ale_q <= 1'b0;
    else if (accept) ale_q <= new_ale;
  end
  assign mem_to_wb_ale = (state_q == ST_FULL) && ale_q;
`endif

  assign held               = (state_q == ST_WAIT) || (state_q == ST_FULL);
  assign o_mem_ready        = ready;
  assign mem_to_wb_valid    = !flush && ((state_q == ST_FULL) ||
                                         ((state_q == ST_WAIT) && dmem_rvalid));
  assign mem_to_wb_rf_wdata = (state_q == ST_WAIT) ? load_data : wdata_q;
  assign mem_to_wb_mem_re   = held && mem_re_q;
  assign mem_to_wb_rf_we    = held && we_q;
  assign mem_to_wb_rf_waddr = waddr_q;
  assign mem_to_wb_pc       = pc_q;
  assign mem_to_wb_inst     = inst_q;
  assign mem_load_pending   = (state_q == ST_WAIT) && !dmem_rvalid;

endmodule

// File: tb/tb_mem_stage_lsu.sv
// Directed and randomized checks of mem_stage_lsu against a transaction-level model.
module tb_mem_stage_lsu;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        flush = 1'b0;
  logic        ex_valid = 1'b0;
  logic        ex_re = 1'b0;
  logic [2:0]  ex_op = 3'd0;
  logic [31:0] ex_alu = '0;
  logic [4:0]  ex_waddr = '0;
  logic        ex_we = 1'b0;
  logic [31:0] ex_pc = '0;
  logic [31:0] ex_inst = '0;
  logic        rvalid = 1'b0;
  logic [31:0] rdata = '0;
  logic        wb_ready = 1'b0;

  logic        ready, valid, o_mem_re, o_we, pending;
  logic [31:0] o_wdata, o_pc, o_inst;
  logic [4:0]  o_waddr;
`ifdef MEM_ALIGN_CHECK_EN
  logic        o_ale;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mem_stage_lsu dut (
    .clk                (clk),
    .rst                (rst),
    .flush              (flush),
    .ex_to_mem_valid    (ex_valid),
    .o_mem_ready        (ready),
    .ex_to_mem_mem_re   (ex_re),
    .ex_to_mem_mem_op   (ex_op),
    .ex_to_mem_alu_res  (ex_alu),
    .ex_to_mem_rf_waddr (ex_waddr),
    .ex_to_mem_rf_we    (ex_we),
    .ex_to_mem_pc       (ex_pc),
    .ex_to_mem_inst     (ex_inst),
    .dmem_rvalid        (rvalid),
    .dmem_rdata         (rdata),
    .mem_to_wb_valid    (valid),
    .i_wb_ready         (wb_ready),
    .mem_to_wb_mem_re   (o_mem_re),
    .mem_to_wb_rf_wdata (o_wdata),
    .mem_to_wb_rf_waddr (o_waddr),
    .mem_to_wb_rf_we    (o_we),
    .mem_to_wb_pc       (o_pc),
    .mem_to_wb_inst     (o_inst),
    .mem_load_pending   (pending)
`ifdef MEM_ALIGN_CHECK_EN
    ,
    .mem_to_wb_ale      (o_ale)
`endif
  );

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0b expected=%0b", tag, obs, exp);
    end
  endtask

  task automatic chkw(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
    end
  endtask

  // Reference extraction written straight from the byte/half selection rules.
  function automatic logic [31:0] ref_load(input logic [2:0] op, input logic [31:0] addr,
                                           input logic [31:0] word);
    logic [31:0] off, b, h;
    off = addr % 4;
    b = (word >> (8 * off)) & 32'hFF;
    h = (word >> (16 * (off / 2))) & 32'hFFFF;
    case (op)
      3'd1:    return (b >= 32'd128) ? b + 32'hFFFF_FF00 : b;
      3'd3:    return b;
      3'd2:    return (h >= 32'd32768) ? h + 32'hFFFF_0000 : h;
      3'd4:    return h;
      default: return word;
    endcase
  endfunction

  function automatic logic ref_mis(input logic [2:0] op, input logic [31:0] addr);
`ifdef MEM_ALIGN_CHECK_EN
    case (op)
      3'd1, 3'd3: return 1'b0;
      3'd2, 3'd4: return (addr % 2) != 0;
      default:    return (addr % 4) != 0;
    endcase
`else
    return (op == 3'd7) && (addr == 32'hFFFF_FFFF) && 1'b0;
`endif
  endfunction

  task automatic cyc();
    @(negedge clk);
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic offer(input logic re, input logic [2:0] op, input logic [31:0] alu,
                       input logic [4:0] wa, input logic we, input logic [31:0] pc);
    ex_valid = 1'b1; ex_re = re; ex_op = op; ex_alu = alu;
    ex_waddr = wa; ex_we = we; ex_pc = pc; ex_inst = pc ^ 32'hA5A5_0000;
  endtask

  task automatic idle();
    ex_valid = 1'b0; ex_re = 1'b0; ex_op = 3'd0; ex_alu = $urandom;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  logic [2:0]  sw_op  [4] = '{3'd1, 3'd3, 3'd2, 3'd4};
  logic [31:0] sw_off [4] = '{32'd3, 32'd3, 32'd2, 32'd0};
  logic [31:0] rd, rd2, exp_d;

  // random-phase model state
  logic        m_held, m_is_load, m_have, m_we, m_ale;
  logic [2:0]  m_op;
  logic [31:0] m_addr, m_wdata, m_pc, m_rd;
  logic [4:0]  m_waddr;
  logic        outstanding, rv, nv, m_rv, avail, exp_ready, mis;
  int          resp_wait;

  initial begin
    // Reset
    #1 rst = 1'b0;
    #2;
    chk1("rst_ready", ready, 1'b1);
    chk1("rst_valid", valid, 1'b0);
    chkw("rst_wdata", o_wdata, 32'h0);
    chkw("rst_waddr", 32'(o_waddr), 32'h0);
    chk1("rst_we", o_we, 1'b0);
    chk1("rst_mem_re", o_mem_re, 1'b0);
    chkw("rst_pc", o_pc, 32'h0);
    chkw("rst_inst", o_inst, 32'h0);
    chk1("rst_pending", pending, 1'b0);
    cyc(); rst = 1'b1;

    // ALU ops, back to back
    cyc(); wb_ready = 1'b1; offer(1'b0, 3'd0, 32'h1234_5678, 5'd3, 1'b1, 32'h100); settle();
    chk1("alu_empty_ready", ready, 1'b1);
    chk1("alu_empty_valid", valid, 1'b0);
    cyc(); offer(1'b0, 3'd0, 32'hAAAA_0001, 5'd4, 1'b1, 32'h104); settle();
    chk1("alu_valid", valid, 1'b1);
    chkw("alu_wdata", o_wdata, 32'h1234_5678);
    chkw("alu_waddr", 32'(o_waddr), 32'd3);
    chk1("alu_we", o_we, 1'b1);
    chk1("alu_ready", ready, 1'b1);
    chkw("alu_pc", o_pc, 32'h100);
    chkw("alu_inst", o_inst, 32'h100 ^ 32'hA5A5_0000);
`ifdef MEM_ALIGN_CHECK_EN
    chk1("alu_ale", o_ale, 1'b0);
`endif
    cyc(); idle(); settle();
    chk1("b2b_valid", valid, 1'b1);
    chkw("b2b_wdata", o_wdata, 32'hAAAA_0001);
    chkw("b2b_waddr", 32'(o_waddr), 32'd4);
    cyc(); settle();
    chk1("alu_done_valid", valid, 1'b0);

    // Sub-word loads against one response word
    for (int i = 0; i < 4; i++) begin
      cyc(); offer(1'b1, sw_op[i], 32'h2000 + sw_off[i], 5'd5, 1'b1, 32'h200); settle();
      cyc(); idle(); rvalid = 1'b1; rdata = 32'h80FF_7F01; settle();
      chk1("sw_valid", valid, 1'b1);
      chkw("sw_wdata", o_wdata, ref_load(sw_op[i], 32'h2000 + sw_off[i], 32'h80FF_7F01));
      chk1("sw_mem_re", o_mem_re, 1'b1);
      cyc(); rvalid = 1'b0; settle();
      chk1("sw_done", valid, 1'b0);
    end

    // Variable latency: response three cycles after accept
    rd = $urandom;
    cyc(); offer(1'b1, 3'd0, 32'h3000, 5'd7, 1'b1, 32'h300); settle();
    for (int i = 0; i < 2; i++) begin
      cyc(); idle(); settle();
      chk1("lat_ready", ready, 1'b0);
      chk1("lat_pending", pending, 1'b1);
      chk1("lat_valid", valid, 1'b0);
      chk1("lat_we", o_we, 1'b1);
    end
    cyc(); rvalid = 1'b1; rdata = rd; settle();
    chk1("lat_pass_valid", valid, 1'b1);
    chk1("lat_pass_ready", ready, 1'b1);
    chk1("lat_pass_pending", pending, 1'b0);
    chkw("lat_pass_wdata", o_wdata, rd);
    cyc(); rvalid = 1'b0; settle();
    chk1("lat_done", valid, 1'b0);

    // WB backpressure while the response arrives
    rd = $urandom;
    exp_d = ref_load(3'd4, 32'h4002, rd);
    cyc(); offer(1'b1, 3'd4, 32'h4002, 5'd9, 1'b1, 32'h400); settle();
    cyc(); idle(); rvalid = 1'b1; rdata = rd; wb_ready = 1'b0; settle();
    chk1("bp_valid", valid, 1'b1);
    chk1("bp_ready", ready, 1'b0);
    chkw("bp_wdata", o_wdata, exp_d);
    for (int i = 0; i < 2; i++) begin
      cyc(); rvalid = 1'b0; rdata = ~rd; settle();
      chk1("bp_hold_valid", valid, 1'b1);
      chkw("bp_hold_wdata", o_wdata, exp_d);
      chk1("bp_hold_pending", pending, 1'b0);
    end
    cyc(); wb_ready = 1'b1; settle();
    chk1("bp_release_valid", valid, 1'b1);
    chkw("bp_release_wdata", o_wdata, exp_d);
    chk1("bp_release_ready", ready, 1'b1);
    cyc(); settle();
    chk1("bp_done", valid, 1'b0);

    // Flush in WAIT without response: drain then empty
    rd2 = $urandom;
    cyc(); offer(1'b1, 3'd0, 32'h5000, 5'd10, 1'b1, 32'h500); settle();
    cyc(); idle(); flush = 1'b1; settle();
    chk1("fl_valid", valid, 1'b0);
    cyc(); flush = 1'b0; settle();
    chk1("drain_valid", valid, 1'b0);
    chk1("drain_ready", ready, 1'b0);
    chk1("drain_we", o_we, 1'b0);
    chk1("drain_pending", pending, 1'b0);
    cyc(); rvalid = 1'b1; rdata = 32'hDEAD_BEEF; settle();
    chk1("drain_rsp_valid", valid, 1'b0);
    chk1("drain_rsp_ready", ready, 1'b0);
    cyc(); rvalid = 1'b0; offer(1'b1, 3'd0, 32'h6000, 5'd11, 1'b1, 32'h600); settle();
    chk1("post_drain_ready", ready, 1'b1);
    cyc(); idle(); rvalid = 1'b1; rdata = rd2; settle();
    chk1("post_drain_valid", valid, 1'b1);
    chkw("post_drain_wdata", o_wdata, rd2);
    chkw("post_drain_waddr", 32'(o_waddr), 32'd11);
    cyc(); rvalid = 1'b0; settle();

    // Flush in FULL under backpressure
    cyc(); wb_ready = 1'b0; offer(1'b0, 3'd0, 32'h77, 5'd12, 1'b1, 32'h700); settle();
    cyc(); idle(); flush = 1'b1; settle();
    chk1("fl_full_valid", valid, 1'b0);
    cyc(); flush = 1'b0; settle();
    chk1("fl_full_after_valid", valid, 1'b0);
    chk1("fl_full_after_ready", ready, 1'b1);

    // Flush in WAIT coinciding with the response goes straight to EMPTY
    cyc(); wb_ready = 1'b1; offer(1'b1, 3'd0, 32'h7000, 5'd13, 1'b1, 32'h800); settle();
    cyc(); idle(); flush = 1'b1; rvalid = 1'b1; rdata = $urandom; settle();
    chk1("fl_rsp_valid", valid, 1'b0);
    cyc(); flush = 1'b0; rvalid = 1'b0; settle();
    chk1("fl_rsp_ready", ready, 1'b1);

    // Misaligned LD_W
    rd = $urandom;
    cyc(); offer(1'b1, 3'd0, 32'h1002, 5'd14, 1'b1, 32'h900); settle();
`ifdef MEM_ALIGN_CHECK_EN
    cyc(); idle(); settle();
    chk1("ale_valid", valid, 1'b1);
    chk1("ale_flag", o_ale, 1'b1);
    chk1("ale_we", o_we, 1'b0);
    chk1("ale_pending", pending, 1'b0);
    cyc(); settle();
    chk1("ale_done", valid, 1'b0);
`else
    cyc(); idle(); rvalid = 1'b1; rdata = rd; settle();
    chk1("mis_valid", valid, 1'b1);
    chkw("mis_wdata", o_wdata, ref_load(3'd0, 32'h1002, rd));
    cyc(); rvalid = 1'b0; settle();
    chk1("mis_done", valid, 1'b0);
`endif

    // Async reset while FULL
    cyc(); wb_ready = 1'b0; offer(1'b0, 3'd0, 32'hCAFE_0001, 5'd15, 1'b1, 32'hA00); settle();
    cyc(); idle(); settle();
    chk1("arst_pre_valid", valid, 1'b1);
    #2 rst = 1'b0;
    #1;
    chk1("arst_valid", valid, 1'b0);
    chk1("arst_ready", ready, 1'b1);
    chkw("arst_wdata", o_wdata, 32'h0);
    chk1("arst_we", o_we, 1'b0);
    chkw("arst_pc", o_pc, 32'h0);
    cyc(); rst = 1'b1; wb_ready = 1'b1; settle();
    chk1("arst_after_valid", valid, 1'b0);

    // Randomized traffic against a transaction-level model
    m_held = 1'b0; m_is_load = 1'b0; m_have = 1'b0; m_we = 1'b0; m_ale = 1'b0;
    m_op = '0; m_addr = '0; m_wdata = '0; m_pc = '0; m_rd = '0; m_waddr = '0;
    outstanding = 1'b0; resp_wait = 0;
    for (int k = 0; k < 500; k++) begin
      cyc();
      rv = 1'b0;
      rd = $urandom;
      if (outstanding) begin
        resp_wait--;
        if (resp_wait == 0) begin
          rv = 1'b1; rd = m_rd; outstanding = 1'b0;
        end
      end else if ($urandom_range(0, 7) == 0) begin
        rv = 1'b1;
      end
      rvalid = rv; rdata = rd;
      wb_ready = ($urandom_range(0, 3) != 0);
      nv = ($urandom_range(0, 2) != 0);
      if (nv) offer($urandom_range(0, 1) == 1, 3'($urandom_range(0, 7)), $urandom,
                    5'($urandom_range(0, 31)), $urandom_range(0, 1) == 1, $urandom);
      else idle();
      settle();

      m_rv = rv && m_held && m_is_load && !m_have;
      if (m_rv) m_wdata = ref_load(m_op, m_addr, rd);
      avail = m_held && (!m_is_load || m_have || m_rv);
      exp_ready = !m_held || (avail && wb_ready);
      chk1("rnd_valid", valid, avail);
      chk1("rnd_ready", ready, exp_ready);
      chk1("rnd_pending", pending, m_held && m_is_load && !m_have && !m_rv);
      if (avail) begin
        chkw("rnd_wdata", o_wdata, m_wdata);
        chkw("rnd_waddr", 32'(o_waddr), 32'(m_waddr));
        chk1("rnd_we", o_we, m_we);
        chkw("rnd_pc", o_pc, m_pc);
`ifdef MEM_ALIGN_CHECK_EN
        chk1("rnd_ale", o_ale, m_ale);
`endif
      end
      if (avail && wb_ready) m_held = 1'b0;
      else if (m_rv) m_have = 1'b1;

      if (nv && exp_ready) begin
        mis = ex_re && ref_mis(ex_op, ex_alu);
        m_held = 1'b1;
        m_is_load = ex_re && !mis;
        m_have = !m_is_load;
        m_we = ex_we && !mis;
        m_ale = mis;
        m_op = ex_op; m_addr = ex_alu; m_wdata = ex_alu;
        m_waddr = ex_waddr; m_pc = ex_pc;
        if (m_is_load) begin
          outstanding = 1'b1;
          resp_wait = int'($urandom_range(1, 4));
          m_rd = $urandom;
        end
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
